// File: rtl/blk_e1b918.sv
// PLIC per-target arbiter: sequential priority scan, eip publish, claim/complete handshake.
// Optional: define PLIC_TARGET_INFLIGHT_MASK_EN to mask claimed-but-not-completed sources.
module blk_e1b918 #(
    parameter int unsigned N_SOURCES = 32,
    parameter int unsigned ID_W      = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SOURCES-1:0]      ip,
    input  logic [N_SOURCES-1:0]      ie,
    input  logic [32*N_SOURCES-1:0]   priority__flat,
    input  logic [31:0]               threshold,
    input  logic                      claim__req,
    output logic                      claim__ack,
    output logic [ID_W-1:0]           claim__id,
    output logic                      clear__valid,
    output logic [ID_W-1:0]           clear__id,
    input  logic                      complete__req,
    input  logic [ID_W-1:0]           complete__id,
    output logic                      complete__valid,
    output logic [ID_W-1:0]           complete__id_out,
    output logic [ID_W-1:0]           max_id,
    output logic                      eip
);

    localparam int unsigned IDX_W     = $clog2(N_SOURCES);
    localparam int unsigned PSEL_W    = IDX_W + 5;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SOURCES - 1);
    localparam logic [31:0]      N_LIMIT   = 32'(N_SOURCES);

    typedef enum logic {ST_SCAN, ST_CLAIM} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ID_W-1:0]    best_id_q, best_id_d;
    logic [31:0]        best_pri_q, best_pri_d;
    logic [ID_W-1:0]    max_id_d, claim_id_d, clear_id_d, complete_id_d;
    logic               eip_d, claim_ack_d, clear_valid_d, complete_valid_d;

    logic [PSEL_W-1:0]  psel;
    logic [31:0]        pri_cur, eff_pri, cand_pri;
    logic [ID_W-1:0]    cand_id, claim_pick;
    logic [N_SOURCES-1:0] masked;
    logic               complete_ok;

`ifdef PLIC_TARGET_INFLIGHT_MASK_EN
    logic [N_SOURCES-1:0] infl_q, infl_d;

    // In-flight tracking: completion of the same id wins over a same-cycle claim.
    always_comb begin
        infl_d = infl_q;
        if (claim__req && (claim_pick != '0)) infl_d[IDX_W'(claim_pick)] = 1'b1;
        if (complete_ok) infl_d[IDX_W'(complete__id)] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) infl_q <= '0;
        else     infl_q <= infl_d;
    end

    assign masked = infl_q;
`else
    assign masked = '0;
`endif

    // Effective priority of the source under evaluation and the updated running best.
    assign psel     = {idx_q, 5'd0};
    assign pri_cur  = priority__flat[psel +: 32];
    assign eff_pri  = (ip[idx_q] && ie[idx_q] && !masked[idx_q]) ? pri_cur : 32'd0;
    assign cand_pri = (eff_pri > best_pri_q) ? eff_pri : best_pri_q;
    assign cand_id  = (eff_pri > best_pri_q) ? ID_W'(idx_q) : best_id_q;

    assign claim_pick  = eip ? max_id : '0;
    assign complete_ok = complete__req && (complete__id != '0) && (32'(complete__id) < N_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_SCAN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN:  if (claim__req) state_d = ST_CLAIM;
            ST_CLAIM: state_d = claim__req ? ST_CLAIM : ST_SCAN;
            default:  state_d = ST_SCAN;
        endcase
    end

    // Next values for scan datapath and registered outputs; a claim pre-empts a publish.
    always_comb begin
        idx_d            = idx_q;
        best_id_d        = best_id_q;
        best_pri_d       = best_pri_q;
        max_id_d         = max_id;
        eip_d            = eip;
        claim_ack_d      = 1'b0;
        claim_id_d       = '0;
        clear_valid_d    = 1'b0;
        clear_id_d       = '0;
        complete_valid_d = complete_ok;
        complete_id_d    = complete_ok ? complete__id : '0;

        if (claim__req) begin
            claim_ack_d   = 1'b1;
            claim_id_d    = claim_pick;
            clear_valid_d = (claim_pick != '0);
            clear_id_d    = claim_pick;
            max_id_d      = '0;
            eip_d         = 1'b0;
            idx_d         = FIRST_IDX;
            best_id_d     = '0;
            best_pri_d    = '0;
        end else if (state_q == ST_CLAIM) begin
            idx_d      = FIRST_IDX;
            best_id_d  = '0;
            best_pri_d = '0;
        end else if (idx_q == LAST_IDX) begin
            max_id_d   = cand_id;
            eip_d      = (cand_pri > threshold);
            idx_d      = FIRST_IDX;
            best_id_d  = '0;
            best_pri_d = '0;
        end else begin
            idx_d      = idx_q + FIRST_IDX;
            best_id_d  = cand_id;
            best_pri_d = cand_pri;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q            <= FIRST_IDX;
            best_id_q        <= '0;
            best_pri_q       <= '0;
            max_id           <= '0;
            eip              <= 1'b0;
            claim__ack       <= 1'b0;
            claim__id        <= '0;
            clear__valid     <= 1'b0;
            clear__id        <= '0;
            complete__valid  <= 1'b0;
            complete__id_out <= '0;
        end else begin
            idx_q            <= idx_d;
            best_id_q        <= best_id_d;
            best_pri_q       <= best_pri_d;
            max_id           <= max_id_d;
            eip              <= eip_d;
            claim__ack       <= claim_ack_d;
            claim__id        <= claim_id_d;
            clear__valid     <= clear_valid_d;
            clear__id        <= clear_id_d;
            complete__valid  <= complete_valid_d;
            complete__id_out <= complete_id_d;
        end
    end

endmodule
